// File: rtl/mips_seq_alu.sv
// mips_seq_alu: MIPS R-type ALU, 1-cycle arith/logic/shift; mult (and div/divu when MIPS_SEQ_ALU_DIV_EN is defined) iterate WIDTH cycles into HI/LO.
// Latency 1 cycle (WIDTH+1 for mult/div); start is ignored while busy, no queueing.
module mips_seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   inp1,
  input  logic [WIDTH-1:0]   inp2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   out,
  output logic               ovf,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011,
                         F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111,
                         F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                         F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV = 6'b011010, F_DIVU = 6'b011011,
                         F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011,
                         F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
                         F_SLT = 6'b101010, F_SLTU = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     out_q, out_d, hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic                 ovf_q, ovf_d, done_q, done_d, neg_q, neg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, prod_step;
  logic [WIDTH:0]       psum;
  logic [WIDTH-1:0]     add_r, sub_r, mag1, mag2;
  logic                 sgn;

  assign add_r = inp1 + inp2;
  assign sub_r = inp1 - inp2;
  // funct[0]=0 selects the signed variant for both mult and div
  assign sgn   = ~funct[0];
  assign mag1  = (sgn && inp1[MSB]) ? -inp1 : inp1;
  assign mag2  = (sgn && inp2[MSB]) ? -inp2 : inp2;

  // prod_q holds {partial sum, remaining multiplier bits}; shift right one bit per cycle
  assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign prod_step = {psum, prod_q[WIDTH-1:1]};

`ifdef MIPS_SEQ_ALU_DIV_EN
  // Divide reuses prod_q as {remainder, dividend/quotient} and mcand_q as divisor
  logic                 rneg_q, rneg_d, qbit;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_diff;
  logic [2*WIDTH-1:0]   div_step;

  assign rem_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign qbit      = rem_shift >= {1'b0, mcand_q};
  assign rem_diff  = rem_shift[WIDTH-1:0] - mcand_q;
  assign div_step  = {(qbit ? rem_diff : rem_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], qbit};
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
`ifdef MIPS_SEQ_ALU_DIV_EN
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        done_d = 1'b1;
        out_d  = '0;
        ovf_d  = 1'b0;
        cnt_d  = '0;
        if (opcode == 6'b000000) begin
          case (funct)
            F_ADD:   begin
              out_d = add_r;
              ovf_d = (inp1[MSB] == inp2[MSB]) && (add_r[MSB] != inp1[MSB]);
            end
            F_ADDU:  out_d = add_r;
            F_SUB:   begin
              out_d = sub_r;
              ovf_d = (inp1[MSB] != inp2[MSB]) && (sub_r[MSB] != inp1[MSB]);
            end
            F_SUBU:  out_d = sub_r;
            F_AND:   out_d = inp1 & inp2;
            F_OR:    out_d = inp1 | inp2;
            F_XOR:   out_d = inp1 ^ inp2;
            F_NOR:   out_d = ~(inp1 | inp2);
            F_SLT:   out_d = {{(WIDTH-1){1'b0}}, $signed(inp1) < $signed(inp2)};
            F_SLTU:  out_d = {{(WIDTH-1){1'b0}}, inp1 < inp2};
            F_SLL:   out_d = inp2 << shamt;
            F_SRL:   out_d = inp2 >> shamt;
            F_SRA:   out_d = $signed(inp2) >>> shamt;
            F_SLLV:  out_d = inp2 << inp1[SHAMT_W-1:0];
            F_SRLV:  out_d = inp2 >> inp1[SHAMT_W-1:0];
            F_SRAV:  out_d = $signed(inp2) >>> inp1[SHAMT_W-1:0];
            F_MFHI:  out_d = hi_q;
            F_MFLO:  out_d = lo_q;
            F_MULT, F_MULTU: begin
              state_d = S_MUL;
              done_d  = 1'b0;
              out_d   = out_q;
              ovf_d   = ovf_q;
              mcand_d = mag1;
              prod_d  = {{WIDTH{1'b0}}, mag2};
              neg_d   = sgn & (inp1[MSB] ^ inp2[MSB]);
            end
`ifdef MIPS_SEQ_ALU_DIV_EN
            F_DIV, F_DIVU: begin
              state_d = S_DIV;
              done_d  = 1'b0;
              out_d   = out_q;
              ovf_d   = ovf_q;
              mcand_d = mag2;
              prod_d  = {{WIDTH{1'b0}}, mag1};
              // a zero divisor must leave the all-ones quotient un-negated
              neg_d   = sgn & (inp1[MSB] ^ inp2[MSB]) & (|inp2);
              rneg_d  = sgn & inp1[MSB];
            end
`endif
            default: ;
          endcase
        end
      end
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == LAST) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          {hi_d, lo_d} = neg_q ? -prod_step : prod_step;
        end
      end
`ifdef MIPS_SEQ_ALU_DIV_EN
      S_DIV: begin
        prod_d = div_step;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          lo_d    = neg_q  ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
          hi_d    = rneg_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
`ifdef MIPS_SEQ_ALU_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
`ifdef MIPS_SEQ_ALU_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign out  = out_q;
  assign ovf  = ovf_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu: a reference model predicts each op into a scoreboard queue,
// entries are popped and compared when the DUT raises done.
module tb_mips_seq_alu;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0]  opcode = 6'd0, funct = 6'd0;
  logic [31:0] inp1 = 32'd0, inp2 = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] out, hi, lo;
  logic        ovf, busy, done;

  int checks = 0, failures = 0;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_out = 32'd0, m_hi = 32'd0, m_lo = 32'd0;
  logic        m_ovf = 1'b0;
  logic [31:0] o_out, o_hi, o_lo;
  logic        o_ovf;
  int          o_lat, o_busy;

  localparam longint MAXI = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINI = -64'sh0000_0000_8000_0000;
  logic [5:0] pool [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                            6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12};

  always #5 clk = ~clk;

  mips_seq_alu dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
    .inp1(inp1), .inp2(inp2), .shamt(shamt),
    .out(out), .ovf(ovf), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic predict(input string nm, input logic [5:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    longint sa, sbv, r, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.name = nm; e.out = 32'd0; e.ovf = 1'b0; e.lat = 1;
    if (op == 6'd0) begin
      case (f)
        6'h20: begin r = sa + sbv; e.out = a + b; e.ovf = (r > MAXI) || (r < MINI); end
        6'h21: e.out = a + b;
        6'h22: begin r = sa - sbv; e.out = a - b; e.ovf = (r > MAXI) || (r < MINI); end
        6'h23: e.out = a - b;
        6'h24: e.out = a & b;
        6'h25: e.out = a | b;
        6'h26: e.out = a ^ b;
        6'h27: e.out = ~(a | b);
        6'h2A: e.out = (sa < sbv) ? 32'd1 : 32'd0;
        6'h2B: e.out = (a < b) ? 32'd1 : 32'd0;
        6'h00: e.out = b << sh;
        6'h02: e.out = b >> sh;
        6'h03: e.out = 32'(sbv >>> sh);
        6'h04: e.out = b << a[4:0];
        6'h06: e.out = b >> a[4:0];
        6'h07: e.out = 32'(sbv >>> a[4:0]);
        6'h10: e.out = m_hi;
        6'h12: e.out = m_lo;
        6'h18: begin p = sa * sbv; {m_hi, m_lo} = p; e.out = m_out; e.ovf = m_ovf; e.lat = 33; end
        6'h19: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; e.out = m_out; e.ovf = m_ovf; e.lat = 33; end
`ifdef MIPS_SEQ_ALU_DIV_EN
        6'h1A: begin
          if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
          else begin q = sa / sbv; rm = sa % sbv; m_lo = 32'(q); m_hi = 32'(rm); end
          e.out = m_out; e.ovf = m_ovf; e.lat = 33;
        end
        6'h1B: begin
          if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
          else begin m_lo = a / b; m_hi = a % b; end
          e.out = m_out; e.ovf = m_ovf; e.lat = 33;
        end
`endif
        default: e.out = 32'd0;
      endcase
    end
    m_out = e.out; m_ovf = e.ovf;
    e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    opcode = op; funct = f; inp1 = a; inp2 = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    o_lat = 1;
    o_busy = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && o_lat < 80) begin
      @(posedge clk); #1;
      o_lat++;
      if (busy === 1'b1) o_busy++;
    end
    o_out = out; o_ovf = ovf; o_hi = hi; o_lo = lo;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out, ovf, hi, lo, busy, done} !== 99'd0) begin
      failures++;
      $display("FAIL reset_state: got out=%h ovf=%b hi=%h lo=%h busy=%b done=%b, expected all zero",
               out, ovf, hi, lo, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [5:0]  top [12] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
    logic [5:0]  tf  [12] = '{6'h20, 6'h20, 6'h22, 6'h24, 6'h00, 6'h03, 6'h2A, 6'h2B, 6'h07, 6'h27, 6'h3F, 6'h20};
    logic [31:0] ta  [12] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd0, 32'h1234, 32'd5};
    logic [31:0] tb  [12] = '{32'd3, 32'd1, 32'd1, 32'h1F, 32'd1, 32'h80000000,
                              32'd1, 32'd1, 32'hF0000000, 32'd0, 32'd1, 32'd6};
    logic [4:0]  ts  [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] tw  [12] = '{32'd2, 32'h80000000, 32'h7FFFFFFF, 32'h1F, 32'd8, 32'hF8000000,
                              32'd1, 32'd0, 32'hFF000000, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic        tv  [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      predict($sformatf("alu%0d", i), top[i], tf[i], ta[i], tb[i], ts[i]);
      run_op(top[i], tf[i], ta[i], tb[i], ts[i]);
      e = sb.pop_front();
      checks++;
      if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo} || o_lat !== e.lat) begin
        failures++;
        $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h lat=%0d, expected out=%h ovf=%b hi=%h lo=%h lat=%0d",
                 e.name, o_out, o_ovf, o_hi, o_lo, o_lat, e.out, e.ovf, e.hi, e.lo, e.lat);
      end
      checks++;
      if (o_out !== tw[i] || o_ovf !== tv[i]) begin
        failures++;
        $display("FAIL alu_const%0d: got out=%h ovf=%b, expected out=%h ovf=%b", i, o_out, o_ovf, tw[i], tv[i]);
      end
    end
  endtask

  task automatic test_mult();
    logic [5:0]  tf  [6] = '{6'h18, 6'h10, 6'h19, 6'h12, 6'h18, 6'h18};
    logic [31:0] ta  [6] = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd7};
    logic [31:0] tb  [6] = '{32'd3, 32'd0, 32'd3, 32'd0, 32'h80000000, 32'hFFFFFFFA};
    logic [31:0] two [6] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] twh [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'h40000000, 32'hFFFFFFFF};
    logic [31:0] twl [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFD6};
    int          tl  [6] = '{33, 1, 33, 1, 33, 33};
    int          tbz [6] = '{32, 0, 32, 0, 32, 32};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      predict($sformatf("mul%0d", i), 6'd0, tf[i], ta[i], tb[i], 5'd0);
      run_op(6'd0, tf[i], ta[i], tb[i], 5'd0);
      e = sb.pop_front();
      checks++;
      if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo}) begin
        failures++;
        $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h, expected out=%h ovf=%b hi=%h lo=%h",
                 e.name, o_out, o_ovf, o_hi, o_lo, e.out, e.ovf, e.hi, e.lo);
      end
      checks++;
      if ({o_out, o_hi, o_lo} !== {two[i], twh[i], twl[i]}) begin
        failures++;
        $display("FAIL mul_const%0d: got out=%h hi=%h lo=%h, expected out=%h hi=%h lo=%h",
                 i, o_out, o_hi, o_lo, two[i], twh[i], twl[i]);
      end
      checks++;
      if (o_lat !== tl[i] || o_busy !== tbz[i]) begin
        failures++;
        $display("FAIL mul_timing%0d: got latency=%0d busy_cycles=%0d, expected latency=%0d busy_cycles=%0d",
                 i, o_lat, o_busy, tl[i], tbz[i]);
      end
    end
  endtask

  task automatic test_div();
`ifdef MIPS_SEQ_ALU_DIV_EN
    localparam int N = 5;
    logic [5:0]  tf  [N] = '{6'h1B, 6'h1A, 6'h1B, 6'h1A, 6'h1A};
    logic [31:0] ta  [N] = '{32'd7, 32'hFFFFFFF9, 32'd5, 32'd7, 32'hFFFFFFFB};
    logic [31:0] tb  [N] = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFE, 32'd0};
    logic [31:0] two [N] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] twh [N] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'd1, 32'hFFFFFFFB};
    logic [31:0] twl [N] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    int          tl  [N] = '{33, 33, 33, 33, 33};
`else
    localparam int N = 2;
    logic [5:0]  tf  [N] = '{6'h1A, 6'h1B};
    logic [31:0] ta  [N] = '{32'd7, 32'd5};
    logic [31:0] tb  [N] = '{32'd2, 32'd0};
    logic [31:0] two [N] = '{32'd0, 32'd0};
    logic [31:0] twh [N] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] twl [N] = '{32'hFFFFFFD6, 32'hFFFFFFD6};
    int          tl  [N] = '{1, 1};
`endif
    exp_t e;
    for (int i = 0; i < N; i++) begin
      predict($sformatf("div%0d", i), 6'd0, tf[i], ta[i], tb[i], 5'd0);
      run_op(6'd0, tf[i], ta[i], tb[i], 5'd0);
      e = sb.pop_front();
      checks++;
      if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo}) begin
        failures++;
        $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h, expected out=%h ovf=%b hi=%h lo=%h",
                 e.name, o_out, o_ovf, o_hi, o_lo, e.out, e.ovf, e.hi, e.lo);
      end
      checks++;
      if ({o_out, o_hi, o_lo} !== {two[i], twh[i], twl[i]} || o_lat !== tl[i]) begin
        failures++;
        $display("FAIL div_const%0d: got out=%h hi=%h lo=%h lat=%0d, expected out=%h hi=%h lo=%h lat=%0d",
                 i, o_out, o_hi, o_lo, o_lat, two[i], twh[i], twl[i], tl[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int ndone = 0;
    predict("busy_mult", 6'd0, 6'h18, 32'd5, 32'd6, 5'd0);
    opcode = 6'd0; funct = 6'h18; inp1 = 32'd5; inp2 = 32'd6; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    funct = 6'h20; inp1 = 32'd1; inp2 = 32'd1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (ndone == 0) begin
          o_out = out; o_ovf = ovf; o_hi = hi; o_lo = lo;
        end
        ndone++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL busy_done_count: got %0d done pulses, expected 1", ndone);
    end
    checks++;
    if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo}) begin
      failures++;
      $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h, expected out=%h ovf=%b hi=%h lo=%h",
               e.name, o_out, o_ovf, o_hi, o_lo, e.out, e.ovf, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      opcode = 6'd0; funct = pool[$urandom_range(17)];
      inp1 = $urandom; inp2 = $urandom; shamt = 5'($urandom); start = 1'b1;
      predict($sformatf("b2b%0d", i), opcode, funct, inp1, inp2, shamt);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || {out, ovf, hi, lo} !== {e.out, e.ovf, e.hi, e.lo}) begin
        failures++;
        $display("FAIL %s: got done=%b out=%h ovf=%b hi=%h lo=%h, expected done=1 out=%h ovf=%b hi=%h lo=%h",
                 e.name, done, out, ovf, hi, lo, e.out, e.ovf, e.hi, e.lo);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_done: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [4:0] sh;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(2))
        0: f = $urandom_range(1) ? 6'h18 : 6'h19;
`ifdef MIPS_SEQ_ALU_DIV_EN
        1: f = $urandom_range(1) ? 6'h1A : 6'h1B;
`endif
        default: f = pool[$urandom_range(17)];
      endcase
      a = $urandom; b = (i == 3) ? 32'd0 : $urandom; sh = 5'($urandom);
      predict($sformatf("rnd%0d", i), 6'd0, f, a, b, sh);
      run_op(6'd0, f, a, b, sh);
      e = sb.pop_front();
      checks++;
      if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo} || o_lat !== e.lat) begin
        failures++;
        $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h lat=%0d, expected out=%h ovf=%b hi=%h lo=%h lat=%0d",
                 e.name, o_out, o_ovf, o_hi, o_lo, o_lat, e.out, e.ovf, e.hi, e.lo, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    predict("pre_rst_add", 6'd0, 6'h20, 32'd1, 32'd1, 5'd0);
    run_op(6'd0, 6'h20, 32'd1, 32'd1, 5'd0);
    e = sb.pop_front();
    checks++;
    if (o_out !== 32'd2 || o_out !== e.out) begin
      failures++;
      $display("FAIL pre_rst_add: got out=%h, expected %h", o_out, e.out);
    end
    opcode = 6'd0; funct = 6'h19; inp1 = 32'hFFFFFFFF; inp2 = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out, ovf, hi, lo, busy, done} !== 99'd0) begin
      failures++;
      $display("FAIL async_reset: got out=%h ovf=%b hi=%h lo=%h busy=%b done=%b, expected all zero",
               out, ovf, hi, lo, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_out = 32'd0; m_ovf = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    predict("post_rst_add", 6'd0, 6'h20, 32'd3, 32'd4, 5'd0);
    run_op(6'd0, 6'h20, 32'd3, 32'd4, 5'd0);
    e = sb.pop_front();
    checks++;
    if ({o_out, o_ovf, o_hi, o_lo} !== {e.out, e.ovf, e.hi, e.lo} || o_out !== 32'd7 || o_lat !== 1) begin
      failures++;
      $display("FAIL %s: got out=%h ovf=%b hi=%h lo=%h lat=%0d, expected out=%h ovf=%b hi=%h lo=%h lat=1",
               e.name, o_out, o_ovf, o_hi, o_lo, o_lat, e.out, e.ovf, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    if (failures == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/mips_seq_alu.md
# mips_seq_alu

Parametrised multi-cycle R-type ALU, successor to the combinational `ALU`. Executes MIPS R-type arithmetic, logic and shift functions in one cycle, and runs mult/multu/div/divu as `WIDTH`-cycle iterative operations into internal HI/LO registers. It sits in the execute stage behind a start/busy/done handshake, so the datapath stalls only on multiply and divide.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 8, power of two.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width (5 at default).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only when `busy`=0.
- `opcode` input 6: must be 6'b000000 (R-type).
- `funct` input 6: MIPS function code.
- `inp1` input WIDTH: rs operand.
- `inp2` input WIDTH: rt operand.
- `shamt` input SHAMT_W: immediate shift amount.
- `out` output WIDTH: registered result.
- `ovf` output 1: signed overflow of add/sub, registered with `out`.
- `hi`, `lo` output WIDTH: HI/LO registers.
- `busy` output 1: multi-cycle op in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, MUL, DIV. The accept edge is the rising edge with `start`=1 in IDLE. Operands and funct are latched there.
- One-cycle functions, with `out` written on the accept edge:
  - add 100000, addu 100001, sub 100010, subu 100011. `ovf` is set only for add/sub on signed overflow; all other ops clear it.
  - and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010 (signed) and sltu 101011 return 1 or 0, zero-extended.
  - sll 000000, srl 000010, sra 000011 shift `inp2` by `shamt`.
  - sllv 000100, srlv 000110, srav 000111 shift `inp2` by `inp1[SHAMT_W-1:0]`.
  - mfhi 010000 / mflo 010010: `out` = `hi` / `lo`.
- mult 011000 / multu 011001 → MUL:
  - Shift-add over magnitudes, one bit per cycle, `WIDTH` iterations.
  - Signed: 2's-complement negate the 2·WIDTH product if operand signs differ.
  - `{hi,lo}` = product. `out` is unchanged.
- div 011010 / divu 011011 → DIV:
  - Restoring division, one quotient bit per cycle, `WIDTH` iterations.
  - `lo` = quotient, `hi` = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero runs full length and gives `lo` = all ones, `hi` = `inp1`, for both signed and unsigned.
- Non-zero `opcode` or undefined funct completes in one cycle with `out`=0 and `ovf`=0. `hi`/`lo` are unchanged.
- `hi`/`lo` change only at the final edge of mult/div. Intermediate values live in private registers.

## Timing
- Reset values: `out`=0, `ovf`=0, `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE. Reset mid-operation aborts immediately, with no `done` and `hi`/`lo` zeroed.
- One-cycle op accepted at edge N:
  - `out`/`ovf` valid and `done`=1 in the cycle after N.
  - Back-to-back starts accepted every cycle.
- Mult/div accepted at edge N:
  - `busy`=1 from after edge N until after edge N+WIDTH.
  - Iterations run on edges N+1..N+WIDTH.
  - `hi`/`lo` are written and `done`=1 in the cycle after edge N+WIDTH, when `busy` returns to 0.
  - Latency is WIDTH+1 cycles from accept to `done`.
- `start` while `busy`=1 is ignored; there is no queue.
- A new `start` may be accepted on the same edge `done` is high.
- `done` is high for exactly one cycle per accepted op.

## Configuration
- `MIPS_SEQ_ALU_DIV_EN`:
  - Defined: DIV state and divider datapath are present, with div/divu as above.
  - Undefined: divider is omitted. div/divu are treated as undefined funct (one cycle, `out`=0, `hi`/`lo` unchanged). mult/multu are unaffected.

## Test plan
- Reset, then add with `inp1`=0xFFFFFFFF, `inp2`=0x00000003 → next cycle `out`=0x00000002, `ovf`=0, `done`=1. Add 0x7FFFFFFF+1 → `ovf`=1.
- And with 0xFFFFFFFF, 0x0000001F → `out`=0x0000001F. sll with `inp2`=1, `shamt`=3 → `out`=0x00000008. sra with `inp2`=0x80000000, `shamt`=4 → 0xF8000000.
- mult with 0xFFFFFFFF × 0x00000003:
  - `busy` for 32 cycles, `done` 33 cycles after accept.
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD; mfhi then returns 0xFFFFFFFF.
- divu 7/2 → `lo`=3, `hi`=1. div −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 5/0 → `lo`=0xFFFFFFFF, `hi`=5. Without the macro, div gives `out`=0 in one cycle with `hi`/`lo` unchanged.
- `start`=1 with add during mult `busy` → ignored, `out` unchanged, exactly one `done`.
- Assert `rst` at iteration 10 of mult → all outputs 0 asynchronously. A following add completes normally.
